// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-channel phase generator.
// Configuration selector encodings used by the config decode.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        CFG_DIV   = 2'd0,
        CFG_PHASE = 2'd1,
        CFG_MASK  = 2'd2,
        CFG_RSVD  = 2'd3
    } cfg_sel_t;

endpackage

// File: rtl/clock_phase_gen_chan.sv
// One output channel: phase register, window compare and registered
// enable pulse / phase clock.
module clock_phase_gen_chan #(
    parameter int unsigned CNT_W  = 3,
    parameter int unsigned RST_PH = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W:0]   div_act,
    input  logic             mask_bit,
    input  logic             phase_we,
    input  logic [CNT_W:0]   phase_data,
    output logic             ch_en,
    output logic             ch_clk
);

    localparam logic [CNT_W:0] PH_RST = RST_PH[CNT_W:0];

    logic [CNT_W:0] phase;
    logic [CNT_W:0] cnt_ext;
    logic [CNT_W:0] diff;
    logic [CNT_W:0] half;
    logic           silent;
    logic           in_window;

    assign cnt_ext = {1'b0, count};
    assign half    = div_act >> 1;
    assign silent  = phase >= div_act;

    // (count - phase) mod div_act; both operands are below div_act when not silent.
    always_comb begin
        diff = cnt_ext - phase;
        if (cnt_ext < phase) begin
            diff = diff + div_act;
        end
    end

    assign in_window = diff < half;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase  <= PH_RST;
            ch_en  <= 1'b0;
            ch_clk <= 1'b0;
        end else begin
            if (phase_we) begin
                phase <= phase_data;
            end
            ch_en <= !stall && mask_bit && !silent && (cnt_ext == phase);
            if (!stall) begin
                ch_clk <= mask_bit && !silent && in_window;
            end
        end
    end

endmodule

// File: rtl/clock_phase_gen.sv
// Free-running divide-by-div_act counter driving NUM_CH phase channels,
// with shadowed divide ratio, per-channel mask and a stall input.
module clock_phase_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned RST_DIV = 8,
    parameter int unsigned RST_PH  = 0
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      stall,
    input  logic                                      cfg_we,
    input  logic [1:0]                                cfg_sel,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W:0]                            cfg_data,
    output logic [NUM_CH-1:0]                         ch_en,
    output logic [NUM_CH-1:0]                         ch_clk,
    output logic                                      wrap,
    output logic [CNT_W-1:0]                          count
);

    localparam int unsigned    CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W:0] DIV_RST = RST_DIV[CNT_W:0];

    logic [CNT_W:0]    div_act;
    logic [CNT_W:0]    div_shd;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] mask_wdata;
    logic [CNT_W:0]    last;
    logic              at_last;
    logic              div_ok;
    cfg_sel_t          sel;

    assign sel     = cfg_sel_t'(cfg_sel);
    assign last    = div_act - 1'b1;
    assign at_last = ({1'b0, count} == last);
    // Accept 2 .. 2**CNT_W: at least bit 1 set, and nothing above the top value.
    assign div_ok  = (|cfg_data[CNT_W:1]) && (!cfg_data[CNT_W] || (cfg_data[CNT_W-1:0] == '0));

    if (NUM_CH <= CNT_W + 1) begin : g_mask_narrow
        assign mask_wdata = cfg_data[NUM_CH-1:0];
    end else begin : g_mask_wide
        assign mask_wdata = {{(NUM_CH - CNT_W - 1){1'b0}}, cfg_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count   <= '0;
            div_act <= DIV_RST;
            div_shd <= DIV_RST;
            mask    <= '1;
            wrap    <= 1'b0;
        end else begin
            wrap <= !stall && at_last;
            if (!stall) begin
                count <= at_last ? '0 : count + 1'b1;
            end
            // Ratio only changes on the wrap, so a period is never cut short.
            if (!stall && at_last) begin
                div_act <= div_shd;
            end
            if (cfg_we && sel == CFG_DIV && div_ok) begin
                div_shd <= cfg_data;
            end
            if (cfg_we && sel == CFG_MASK) begin
                mask <= mask_wdata;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        clock_phase_gen_chan #(
            .CNT_W  (CNT_W),
            .RST_PH (RST_PH)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .stall      (stall),
            .count      (count),
            .div_act    (div_act),
            .mask_bit   (mask[c]),
            .phase_we   (cfg_we && sel == CFG_PHASE && cfg_ch == CH_W'(c)),
            .phase_data (cfg_data),
            .ch_en      (ch_en[c]),
            .ch_clk     (ch_clk[c])
        );
    end

endmodule
